// File: rtl/bus_demux2.sv
// Routes one upstream memory request stream to a RAM target (0) or a decoded
// peripheral window (1), one transaction at a time, with a response timeout.
module bus_demux2 #(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  T1_BASE   = 32'h1000_0000,
  parameter logic [WIDTH-1:0]  T1_MASK   = 32'hF000_0000,
  parameter int                TIMEOUT   = 255,
  parameter logic [WIDTH-1:0]  ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_addr,
  input  logic                 req_write,
  input  logic [WIDTH-1:0]     req_wdata,
  input  logic [WIDTH/8-1:0]   req_wmask,
  output logic                 resp_valid,
  output logic [WIDTH-1:0]     resp_rdata,
  output logic                 resp_err,
  output logic                 stray_err,
  output logic                 t0_req_valid,
  input  logic                 t0_req_ready,
  output logic [WIDTH-1:0]     t0_addr,
  output logic                 t0_write,
  output logic [WIDTH-1:0]     t0_wdata,
  output logic [WIDTH/8-1:0]   t0_wmask,
  input  logic                 t0_resp_valid,
  input  logic [WIDTH-1:0]     t0_resp_rdata,
  output logic                 t1_req_valid,
  input  logic                 t1_req_ready,
  output logic [WIDTH-1:0]     t1_addr,
  output logic                 t1_write,
  output logic [WIDTH-1:0]     t1_wdata,
  output logic [WIDTH/8-1:0]   t1_wmask,
  input  logic                 t1_resp_valid,
  input  logic [WIDTH-1:0]     t1_resp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam int             CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  CNT_LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0]  CNT_MAX   = '1;

  state_t               state_reg;
  logic                 sel_reg;
  logic [WIDTH-1:0]     addr_reg;
  logic                 write_reg;
  logic [WIDTH-1:0]     wdata_reg;
  logic [WIDTH/8-1:0]   wmask_reg;
  logic [CW-1:0]        cnt_reg;

  logic [1:0]           tgt_ready;
  logic [1:0]           tgt_resp_valid;
  logic [1:0]           stray_hit;
  logic [WIDTH-1:0]     tgt_rdata [2];
  logic                 sel_ready;
  logic                 sel_resp;
  logic                 timed_out;

  assign tgt_ready      = {t1_req_ready, t0_req_ready};
  assign tgt_resp_valid = {t1_resp_valid, t0_resp_valid};
  assign tgt_rdata[0]   = t0_resp_rdata;
  assign tgt_rdata[1]   = t1_resp_rdata;

  assign sel_ready = tgt_ready[sel_reg];
  assign sel_resp  = tgt_resp_valid[sel_reg];
  assign timed_out = (TIMEOUT != 0) && (cnt_reg == CNT_LIMIT);

  // Only the selected target may answer, and only while we wait for it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stray
      assign stray_hit[gi] = tgt_resp_valid[gi] &&
                             !((state_reg == RESP) && (sel_reg == 1'(gi)));
    end
  endgenerate

  assign req_ready    = (state_reg == IDLE);
  assign t0_req_valid = (state_reg == REQ) && !sel_reg;
  assign t1_req_valid = (state_reg == REQ) && sel_reg;

  // Both targets see the latched fields; only the valid is steered.
  assign t0_addr  = addr_reg;
  assign t0_write = write_reg;
  assign t0_wdata = wdata_reg;
  assign t0_wmask = wmask_reg;
  assign t1_addr  = addr_reg;
  assign t1_write = write_reg;
  assign t1_wdata = wdata_reg;
  assign t1_wmask = wmask_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      sel_reg    <= 1'b0;
      addr_reg   <= '0;
      write_reg  <= 1'b0;
      wdata_reg  <= '0;
      wmask_reg  <= '0;
      cnt_reg    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      stray_err  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (|stray_hit) stray_err <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            addr_reg  <= req_addr;
            write_reg <= req_write;
            wdata_reg <= req_wdata;
            wmask_reg <= req_wmask;
            sel_reg   <= ((req_addr & T1_MASK) == T1_BASE);
            state_reg <= REQ;
          end
        end
        REQ: begin
          if (sel_ready) begin
            cnt_reg   <= '0;
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CW'(1);
          // A response on the timeout cycle still completes normally.
          if (sel_resp) begin
            resp_rdata <= tgt_rdata[sel_reg];
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state_reg  <= IDLE;
          end else if (timed_out) begin
            resp_rdata <= ERR_RDATA;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_demux2.md
Name: bus_demux2

Overview:
- Routes a single upstream data-memory request stream (core LSU side) to one of two downstream targets: target 0 = default/RAM, target 1 = address-decoded peripheral window.
- Returns the selected target's response upstream.
- Fan-out counterpart of the 2:1 datapath multiplexer: one initiator in, two responders out.
- Single outstanding transaction, registered in both directions, with a response timeout so a dead target cannot hang the core.

Parameters:
- WIDTH, 32, address and data width.
- T1_BASE, 32'h1000_0000, target-1 window base.
- T1_MASK, 32'hF000_0000, decode mask. Target 1 selected iff (addr & T1_MASK) == T1_BASE.
- TIMEOUT, 255, max cycles in RESP before error completion. 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on timeout.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  upstream request valid
- req_ready  out  1  upstream request accepted when valid&&ready
- req_addr  in  WIDTH  request address
- req_write  in  1  1=write, 0=read
- req_wdata  in  WIDTH  write data
- req_wmask  in  WIDTH/8  byte enables
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  WIDTH  read data (valid with resp_valid)
- resp_err  out  1  response is a timeout error (valid with resp_valid)
- stray_err  out  1  sticky: response from a non-selected or idle target
- tN_req_valid  out  1  target N request valid (N=0,1)
- tN_req_ready  in  1  target N accepts
- tN_addr, tN_write, tN_wdata, tN_wmask  out  as upstream  request fields to target N
- tN_resp_valid  in  1  target N response
- tN_resp_rdata  in  WIDTH  target N read data

Behaviour:
- States: IDLE, REQ, RESP.
- Reset (async, reset_n=0):
  - state=IDLE
  - all tN_req_valid=0, resp_valid=0, resp_err=0, stray_err=0
  - resp_rdata=0, latched request fields=0, sel=0, timeout counter=0
- Reset mid-transaction abandons it. No response is issued upstream.
- req_ready = (state==IDLE). Combinational from state only, never from req_valid.
- IDLE:
  - On req_valid: latch addr/write/wdata/wmask.
  - Latch sel = ((req_addr & T1_MASK) == T1_BASE).
  - Next state REQ.
- REQ:
  - t[sel]_req_valid=1, t[!sel]_req_valid=0.
  - Both targets' field outputs are driven from the latch. Only the valid is gated.
  - Fields are stable until handshake.
  - On t[sel]_req_ready: go to RESP and clear the timeout counter.
- RESP:
  - Counter increments each cycle.
  - On t[sel]_resp_valid: resp_rdata <= t[sel]_resp_rdata, resp_err <= 0, resp_valid pulses next cycle, state -> IDLE.
  - Writes also require a target response; rdata is passed through unchanged.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with no response: resp_rdata <= ERR_RDATA, resp_err <= 1, resp_valid pulse, state -> IDLE.
  - A response arriving on the same cycle as the timeout wins: normal completion, resp_err=0.
- Latency:
  - Accept at cycle c -> tN_req_valid high at c+1.
  - Target response at cycle k -> resp_valid at k+1.
  - Minimum round trip 3 cycles (accept, target accept, target respond) + 1.
- Back-to-back: the state is IDLE on the resp_valid cycle, so req_ready=1 and a new request can be accepted in that same cycle.
- Stray responses set stray_err (sticky until reset) and are otherwise ignored:
  - any tN_resp_valid in IDLE or REQ;
  - t[!sel]_resp_valid in RESP.
- resp_valid is high for exactly one cycle per accepted request.
- resp_rdata and resp_err hold their values until the next completion.
- Counter width is clog2(TIMEOUT+1). It saturates and never wraps.

Test Plan:
- Read to target 0:
  - Stimulus: req addr=0x0000_0040, t0 ready on first REQ cycle, t0_resp_rdata=0x1234_5678 two cycles later.
  - Required: t0_req_valid for 1 cycle, t1_req_valid never, resp_valid one cycle later with rdata=0x1234_5678, resp_err=0.
- Write to target 1:
  - Stimulus: addr=0x1000_0004, wdata=0xA5A5_A5A5, wmask=4'b0011, t1_req_ready held low 3 cycles.
  - Required: t1_req_valid high 4 cycles with fields stable, req_ready=0 throughout, response completes normally.
- Timeout:
  - Stimulus: TIMEOUT=4, target 1 never responds.
  - Required: resp_valid 5 cycles after entering RESP with rdata=0xDEAD_BEEF, resp_err=1, then req_ready=1.
- Stray response:
  - Stimulus: t1_resp_valid pulsed while sel=0 in RESP.
  - Required: stray_err=1 and sticky; the target-0 response still completes correctly.
- Back-to-back:
  - Stimulus: second request presented on the resp_valid cycle.
  - Required: accepted in that cycle, its tN_req_valid rises on the next cycle.
- Reset mid-transaction:
  - Stimulus: reset_n=0 asynchronously while in RESP.
  - Required: all outputs are at reset values immediately, no resp_valid after release, and the next request works normally.
